// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - ECP5 EHXPLLL dynamic phase step sequencer
//
// Purpose: accepts phase-step requests (output select, direction, count),
// drives PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG with fixed setup/pulse/hold
// timing, waits for PLL relock and tracks the phase position of all four
// PLL outputs.
//
// Ports:
//   clk          in   25 MHz reference clock
//   reset        in   synchronous active-high reset
//   pll_locked   in   PLL LOCK (asynchronous, synchronised here)
//   req_valid    in   request valid
//   req_ready    out  request accepted when req_valid && req_ready
//   req_sel      in   output select (0=CLKOP .. 3=CLKOD)
//   req_dir      in   0=delay (+1 per step), 1=advance (-1 per step)
//   req_steps    in   number of step pulses (0..255)
//   busy         out  request in progress
//   done         out  one-cycle completion pulse
//   error        out  sticky lock-timeout flag
//   phase_pos    out  packed positions, output n at [n*POS_W +: POS_W]
//   phasesel     out  PLL PHASESEL[1:0]
//   phasedir     out  PLL PHASEDIR
//   phasestep    out  PLL PHASESTEP (idle high, active low)
//   phaseloadreg out  PLL PHASELOADREG (held high)
module pll_phase_ctrl #(
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 2,
  parameter int HOLD_CYC     = 2,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int PHASE_STEPS  = 64,
  parameter int POS_W        = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic               req_dir,
  input  logic [7:0]         req_steps,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [4*POS_W-1:0] phase_pos,
  output logic [1:0]         phasesel,
  output logic               phasedir,
  output logic               phasestep,
  output logic               phaseloadreg
);

  // One timer serves the SETUP/PULSE/HOLD phases and the total RELOCK time.
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_RELOCK, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               sync1_q, locked_s_q;
  logic [CW-1:0]      tmr_q, tmr_d;
  logic [SW-1:0]      stab_q, stab_d;
  logic [7:0]         rem_q, rem_d;
  logic [1:0]         sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               err_q, err_d;
  logic [4*POS_W-1:0] pos_q, pos_d;
  logic               step_q;
  logic [POS_W-1:0]   cur_pos, nxt_pos;

  assign req_ready    = (state_q == S_IDLE) && locked_s_q && !reset;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign error        = err_q;
  assign phase_pos    = pos_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = 1'b1;

  // Modular +/-1 of the selected output; explicit wrap so PHASE_STEPS need
  // not be a power of two.
  always_comb begin
    cur_pos = pos_q[int'(sel_q)*POS_W +: POS_W];
    if (!dir_q) begin
      nxt_pos = (cur_pos == POS_W'(PHASE_STEPS - 1)) ? '0 : cur_pos + POS_W'(1);
    end else begin
      nxt_pos = (cur_pos == '0) ? POS_W'(PHASE_STEPS - 1) : cur_pos - POS_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + CW'(1);
    stab_d  = stab_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    err_d   = err_q;
    pos_d   = pos_q;
    case (state_q)
      S_IDLE: begin
        tmr_d  = '0;
        stab_d = '0;
        if (req_valid && req_ready) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          rem_d   = req_steps;
          err_d   = 1'b0;
          state_d = (req_steps != 8'd0) ? S_SETUP : S_DONE;
        end
      end
      S_SETUP: begin
        if (tmr_q == CW'(SETUP_CYC - 1)) begin
          tmr_d   = '0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (tmr_q == CW'(PULSE_CYC - 1)) begin
          tmr_d = '0;
          pos_d[int'(sel_q)*POS_W +: POS_W] = nxt_pos;
          rem_d   = rem_q - 8'd1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tmr_q == CW'(HOLD_CYC - 1)) begin
          tmr_d   = '0;
          stab_d  = '0;
          state_d = (rem_q != 8'd0) ? S_SETUP : S_RELOCK;
        end
      end
      S_RELOCK: begin
        // Lock only counts while continuously asserted; a drop restarts it.
        stab_d = locked_s_q ? stab_q + SW'(1) : '0;
        if (stab_d == SW'(LOCK_STABLE)) begin
          state_d = S_DONE;
        end else if (tmr_q == CW'(LOCK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      tmr_q      <= '0;
      stab_q     <= '0;
      rem_q      <= '0;
      sel_q      <= 2'd0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
      pos_q      <= '0;
      step_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
      tmr_q      <= tmr_d;
      stab_q     <= stab_d;
      rem_q      <= rem_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      pos_q      <= pos_d;
      // Registered from next state so the PLL sees a glitch-free strobe.
      step_q     <= (state_d != S_PULSE);
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb/tb_pll_phase_ctrl.sv - self-checking bench for pll_phase_ctrl
module tb_pll_phase_ctrl;

  localparam int SETUP_CYC    = 2;
  localparam int PULSE_CYC    = 2;
  localparam int HOLD_CYC     = 2;
  localparam int LOCK_STABLE  = 16;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int PHASE_STEPS  = 64;
  localparam int POS_W        = 6;
  localparam int STEP_CYC     = SETUP_CYC + PULSE_CYC + HOLD_CYC;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pll_locked = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_sel = 2'd0;
  logic             req_dir = 1'b0;
  logic [7:0]       req_steps = 8'd0;
  logic             busy, done, error;
  logic [4*POS_W-1:0] phase_pos;
  logic [1:0]       phasesel;
  logic             phasedir, phasestep, phaseloadreg;

  int checks = 0;
  int errors = 0;
  int model_pos[4];

  pll_phase_ctrl #(
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC),
    .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .PHASE_STEPS(PHASE_STEPS), .POS_W(POS_W)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_steps(req_steps), .busy(busy), .done(done),
    .error(error), .phase_pos(phase_pos), .phasesel(phasesel),
    .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg)
  );

  always #20 clk = ~clk;

  function automatic logic [4*POS_W-1:0] packed_model();
    logic [4*POS_W-1:0] v;
    v = '0;
    for (int n = 0; n < 4; n++) v[n*POS_W +: POS_W] = model_pos[n][POS_W-1:0];
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, busy, done, error, phasestep, phaseloadreg, phasedir} !== 7'b0000111 ||
        phase_pos !== '0 || phasesel !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: ready=%b busy=%b done=%b err=%b step=%b load=%b dir=%b pos=%h sel=%0d, required 0 0 0 0 1 1 1 pos=0 sel=0",
               req_ready, busy, done, error, phasestep, phaseloadreg, phasedir, phase_pos, phasesel);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_cycle2: req_ready=%b, required 0", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_cycle3: req_ready=%b, required 1", req_ready);
    end
    for (int n = 0; n < 4; n++) model_pos[n] = 0;
  endtask

  // Issues one request and checks the whole waveform against the model.
  // lock_low drops pll_locked right after acceptance (forces a timeout);
  // hold_valid keeps req_valid high with junk while busy (must be ignored).
  task automatic run_req(input string name, input logic [1:0] sel, input logic dir,
                         input int steps, input bit lock_low, input bit hold_valid);
    int w, k, lat, exp_lat, run;
    int lows[$];
    int widths[$];
    bit sel_bad, busy_bad, prev_low, exp_err;
    logic [4*POS_W-1:0] exp_pos;
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_wait: req_ready=%b, required 1", name, req_ready);
    end
    req_sel = sel;
    req_dir = dir;
    req_steps = steps[7:0];
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (lock_low) pll_locked = 1'b0;
    // Model: net displacement modulo the period.
    model_pos[sel] = (((model_pos[sel] + (dir ? -steps : steps)) % PHASE_STEPS) + PHASE_STEPS) % PHASE_STEPS;
    exp_pos = packed_model();
    exp_err = lock_low && steps != 0;
    exp_lat = (steps == 0) ? 1 : steps * STEP_CYC + (lock_low ? LOCK_TIMEOUT : LOCK_STABLE) + 1;
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL %s_error_clear: error=%b, required 0", name, error);
    end
    k = 1; lat = -1; run = 0; prev_low = 0; sel_bad = 0; busy_bad = 0;
    while (k < 6000) begin
      if (phasestep === 1'b0) begin
        if (!prev_low) lows.push_back(k);
        run++;
        prev_low = 1;
      end else begin
        if (prev_low) widths.push_back(run);
        run = 0;
        prev_low = 0;
      end
      if (phasesel !== sel || phasedir !== dir) sel_bad = 1;
      if (busy !== 1'b1) busy_bad = 1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (hold_valid) begin
        req_valid = 1'b1;
        req_sel = 2'($urandom_range(0, 3));
        req_dir = 1'($urandom_range(0, 1));
        req_steps = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      k++;
    end
    req_valid = 1'b0;
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: done at %0d, required %0d", name, lat, exp_lat);
    end
    checks++;
    if (lows.size() != steps) begin
      errors++;
      $display("FAIL %s_pulse_count: %0d pulses, required %0d", name, lows.size(), steps);
    end
    for (int i = 0; i < lows.size(); i++) begin
      int exp_start;
      exp_start = SETUP_CYC + 1 + i * STEP_CYC;
      checks++;
      if (lows[i] != exp_start || i >= widths.size() || widths[i] != PULSE_CYC) begin
        errors++;
        $display("FAIL %s_pulse%0d: start=%0d width=%0d, required start=%0d width=%0d", name, i,
                 lows[i], (i < widths.size()) ? widths[i] : -1, exp_start, PULSE_CYC);
      end
    end
    checks++;
    if (sel_bad || busy_bad) begin
      errors++;
      $display("FAIL %s_stable: sel_dir_changed=%0d busy_dropped=%0d, required 0 0", name, sel_bad, busy_bad);
    end
    checks++;
    if (error !== exp_err || phase_pos !== exp_pos || phaseloadreg !== 1'b1) begin
      errors++;
      $display("FAIL %s_result: error=%b pos=%h load=%b, required error=%b pos=%h load=1",
               name, error, phase_pos, phaseloadreg, exp_err, exp_pos);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || error !== exp_err) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b error=%b, required 0 0 %b", name, done, busy, error, exp_err);
    end
  endtask

  task automatic test_directed();
    run_req("delay3", 2'd0, 1'b0, 3, 0, 0);
    checks++;
    if (phase_pos[5:0] !== 6'd3) begin
      errors++;
      $display("FAIL delay3_pos0: pos=%0d, required 3", phase_pos[5:0]);
    end
    run_req("advance_wrap", 2'd2, 1'b1, 1, 0, 0);
    checks++;
    if (phase_pos[17:12] !== 6'd63 || phase_pos[5:0] !== 6'd3) begin
      errors++;
      $display("FAIL wrap_pos2: pos2=%0d pos0=%0d, required 63 3", phase_pos[17:12], phase_pos[5:0]);
    end
    run_req("zero_steps", 2'd1, 1'b0, 0, 0, 0);
    run_req("wrap_up", 2'd2, 1'b0, 2, 0, 0);
    run_req("max_steps", 2'd3, 1'b0, 255, 0, 1);
  endtask

  task automatic test_timeout();
    run_req("timeout", 2'd1, 1'b1, 2, 1, 0);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || error !== 1'b1) begin
        errors++;
        $display("FAIL unlocked_idle: ready=%b error=%b, required 0 1", req_ready, error);
      end
    end
    pll_locked = 1'b1;
    run_req("after_timeout", 2'd1, 1'b0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_req("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 12), 0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_pulse();
    int w;
    int low_seen;
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    req_sel = 2'd1; req_dir = 1'b0; req_steps = 8'd5; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (SETUP_CYC) @(negedge clk);
    checks++;
    if (phasestep !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulse_reached: phasestep=%b, required 0", phasestep);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) model_pos[n] = 0;
    checks++;
    if (phasestep !== 1'b1 || busy !== 1'b0 || phase_pos !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pulse: step=%b busy=%b pos=%h done=%b, required 1 0 0 0",
               phasestep, busy, phase_pos, done);
    end
    low_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (phasestep !== 1'b1 || busy !== 1'b0) low_seen++;
    end
    checks++;
    if (low_seen != 0) begin
      errors++;
      $display("FAIL rst_no_more_pulses: %0d active cycles, required 0", low_seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_random();
    test_reset_mid_pulse();
    run_req("post_reset", 2'd0, 1'b1, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
